tdp_ram_pipe: RTL and testbench

Single-clock true-dual-port RAM with an arbitrary power-of-two width ratio between ports A and B, a configurable output pipeline with per-port read-valid tracking, deterministic write-collision resolution, and a saturating collision counter. It is the next-generation BRAM core behind the wishbone and DSP buffer blocks, replacing separate symmetric/asymmetric instantiation with one parametrised block. Either port may be the wide one.

---
 rtl/tdp_ram_pipe.sv | 148 ++++++++++++++
 tb/tb_tdp_ram_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_pipe.sv
// Single-clock true-dual-port RAM with a power-of-two width ratio between ports,
// read pipeline with valid tokens, and a saturating write-collision counter.
// Optional macro TDP_RAM_BYPASS_EN adds write-first cross-port read forwarding.
module tdp_ram_pipe #(
  parameter int WIDTHA      = 16,
  parameter int ADDRWIDTHA  = 8,
  parameter int WIDTHB      = 4,
  parameter int ADDRWIDTHB  = 10,
  parameter int N_REGISTERS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enaA,
  input  logic                  weA,
  input  logic [ADDRWIDTHA-1:0] addrA,
  input  logic [WIDTHA-1:0]     diA,
  output logic [WIDTHA-1:0]     doA,
  output logic                  vldA,
  input  logic                  enaB,
  input  logic                  weB,
  input  logic [ADDRWIDTHB-1:0] addrB,
  input  logic [WIDTHB-1:0]     diB,
  output logic [WIDTHB-1:0]     doB,
  output logic                  vldB,
  input  logic                  col_clr,
  output logic [15:0]           col_cnt
);

  localparam bit A_WIDE      = (WIDTHA >= WIDTHB);
  localparam int WW          = A_WIDE ? WIDTHA : WIDTHB;
  localparam int NW          = A_WIDE ? WIDTHB : WIDTHA;
  localparam int RATIO       = WW / NW;
  localparam int LOG2R       = $clog2(RATIO);
  localparam int WAW         = A_WIDE ? ADDRWIDTHA : ADDRWIDTHB;
  localparam int NAW         = A_WIDE ? ADDRWIDTHB : ADDRWIDTHA;
  localparam int DEPTH       = 1 << WAW;
  localparam int LW          = (LOG2R > 0) ? LOG2R : 1;
  localparam int SHIFT_A     = A_WIDE ? 0 : LOG2R;
  localparam int SHIFT_B     = A_WIDE ? LOG2R : 0;
  localparam int LANE_MASK_A = A_WIDE ? 0 : RATIO - 1;
  localparam int LANE_MASK_B = A_WIDE ? RATIO - 1 : 0;

  if ((WW % NW) != 0 || (1 << LOG2R) != RATIO) begin : g_bad_ratio
    $error("tdp_ram_pipe: width ratio %0d/%0d is not a power of two", WW, NW);
  end
  if (NAW != WAW + LOG2R) begin : g_bad_addr
    $error("tdp_ram_pipe: narrow address width must be wide width + log2(ratio)");
  end
  if (N_REGISTERS < 0 || N_REGISTERS > 4) begin : g_bad_regs
    $error("tdp_ram_pipe: N_REGISTERS must be in 0..4");
  end

  logic [WW-1:0]  mem [DEPTH];
  logic [WAW-1:0] word_a, word_b;
  logic [LW-1:0]  lane_a, lane_b;
  logic [WW-1:0]  mask_a, mask_b, data_a, data_b;
  logic [WW-1:0]  wmask_a, wdata_a, raw_a, raw_b;
  logic           wr_a, wr_b, rd_a, rd_b, same_word, collision;
  logic [WIDTHA-1:0] rd_data_a_d;
  logic [WIDTHB-1:0] rd_data_b_d;

  // Both ports are mapped onto wide-word coordinates: word index, bit mask, shifted data.
  always_comb begin
    // NOTE: combinational logic uses blocking '=', and every output gets a value
    // before any conditional override so no latch is inferred.
    wr_a   = enaA & weA;
    wr_b   = enaB & weB;
    rd_a   = enaA & ~weA;
    rd_b   = enaB & ~weB;
    word_a = WAW'(addrA >> SHIFT_A);
    word_b = WAW'(addrB >> SHIFT_B);
    lane_a = LW'(addrA & ADDRWIDTHA'(LANE_MASK_A));
    lane_b = LW'(addrB & ADDRWIDTHB'(LANE_MASK_B));
    mask_a = WW'({WIDTHA{1'b1}}) << (lane_a * WIDTHA);
    mask_b = WW'({WIDTHB{1'b1}}) << (lane_b * WIDTHB);
    data_a = WW'(diA) << (lane_a * WIDTHA);
    data_b = WW'(diB) << (lane_b * WIDTHB);

    same_word = wr_a & wr_b & (word_a == word_b);
    collision = same_word & (|(mask_a & mask_b));
    // Same-word double write folds into one update; A's bits take precedence.
    wmask_a = mask_a | (same_word ? mask_b : '0);
    wdata_a = (data_a & mask_a) | (same_word ? (data_b & mask_b & ~mask_a) : '0);

    raw_a = mem[word_a];
    raw_b = mem[word_b];
`ifdef TDP_RAM_BYPASS_EN
    if (wr_b && (word_b == word_a)) raw_a = (raw_a & ~mask_b) | (data_b & mask_b);
    if (wr_a && (word_a == word_b)) raw_b = (raw_b & ~mask_a) | (data_a & mask_a);
`endif
    rd_data_a_d = WIDTHA'(raw_a >> (lane_a * WIDTHA));
    rd_data_b_d = WIDTHB'(raw_b >> (lane_b * WIDTHB));
  end

  // NOTE: the storage array has no reset; rst_n clears only control and output state,
  // so memory contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_a) mem[word_a] <= (mem[word_a] & ~wmask_a) | wdata_a;
    if (wr_b && !same_word) mem[word_b] <= (mem[word_b] & ~mask_b) | (data_b & mask_b);
  end

  logic [WIDTHA-1:0]  pipe_a_q [N_REGISTERS+1];
  logic [WIDTHB-1:0]  pipe_b_q [N_REGISTERS+1];
  logic [N_REGISTERS:0] vld_a_q, vld_b_q;

  // Data stages load only when a valid token passes, so the last stage holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_q <= '0;
      vld_b_q <= '0;
      for (int i = 0; i <= N_REGISTERS; i++) begin
        pipe_a_q[i] <= '0;
        pipe_b_q[i] <= '0;
      end
    end else begin
      vld_a_q[0] <= rd_a;
      vld_b_q[0] <= rd_b;
      if (rd_a) pipe_a_q[0] <= rd_data_a_d;
      if (rd_b) pipe_b_q[0] <= rd_data_b_d;
      for (int i = 1; i <= N_REGISTERS; i++) begin
        vld_a_q[i] <= vld_a_q[i-1];
        vld_b_q[i] <= vld_b_q[i-1];
        if (vld_a_q[i-1]) pipe_a_q[i] <= pipe_a_q[i-1];
        if (vld_b_q[i-1]) pipe_b_q[i] <= pipe_b_q[i-1];
      end
    end
  end

  assign doA  = pipe_a_q[N_REGISTERS];
  assign doB  = pipe_b_q[N_REGISTERS];
  assign vldA = vld_a_q[N_REGISTERS];
  assign vldB = vld_b_q[N_REGISTERS];

  logic [15:0] col_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
    end else if (col_clr) begin
      col_cnt_q <= collision ? 16'd1 : 16'd0;
    end else if (collision && (col_cnt_q != 16'hFFFF)) begin
      col_cnt_q <= col_cnt_q + 16'd1;
    end
  end

  assign col_cnt = col_cnt_q;

endmodule

// File: tb/tb_tdp_ram_pipe.sv
// Bench for tdp_ram_pipe: default asymmetric instance against a nibble-addressed
// reference model, plus a symmetric 32-bit instance with directed checks.
module tb_tdp_ram_pipe;

  localparam int N = 2;
`ifdef TDP_RAM_BYPASS_EN
  localparam logic [3:0] RDW_EXP = 4'h2;
`else
  localparam logic [3:0] RDW_EXP = 4'h0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ena_a, we_a, ena_b, we_b, col_clr;
  logic [7:0]  addr_a;
  logic [9:0]  addr_b;
  logic [15:0] di_a, do_a;
  logic [3:0]  di_b, do_b;
  logic        vld_a, vld_b;
  logic [15:0] col_cnt;

  tdp_ram_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .enaA(ena_a), .weA(we_a), .addrA(addr_a), .diA(di_a), .doA(do_a), .vldA(vld_a),
    .enaB(ena_b), .weB(we_b), .addrB(addr_b), .diB(di_b), .doB(do_b), .vldB(vld_b),
    .col_clr(col_clr), .col_cnt(col_cnt)
  );

  logic        s_ena_a, s_we_a, s_ena_b, s_we_b, s_col_clr, s_vld_a, s_vld_b;
  logic [8:0]  s_addr_a, s_addr_b;
  logic [31:0] s_di_a, s_di_b, s_do_a, s_do_b;
  logic [15:0] s_col_cnt;

  tdp_ram_pipe #(
    .WIDTHA(32), .ADDRWIDTHA(9), .WIDTHB(32), .ADDRWIDTHB(9), .N_REGISTERS(0)
  ) dut_sym (
    .clk(clk), .rst_n(rst_n),
    .enaA(s_ena_a), .weA(s_we_a), .addrA(s_addr_a), .diA(s_di_a), .doA(s_do_a), .vldA(s_vld_a),
    .enaB(s_ena_b), .weB(s_we_b), .addrB(s_addr_b), .diB(s_di_b), .doB(s_do_b), .vldB(s_vld_b),
    .col_clr(s_col_clr), .col_cnt(s_col_cnt)
  );

  // Reference model: the RAM viewed as 1024 nibbles; A word w is nibbles 4w..4w+3.
  typedef struct { int due; logic [15:0] val; } tok_t;
  logic [3:0]  nib [1024];
  tok_t        qa[$], qb[$];
  int          m_col;
  int          cyc;
  bit          exp_vld_a, exp_vld_b;
  logic [15:0] last_a;
  logic [3:0]  last_b;
  int          checks, errors;

  task automatic idle();
    ena_a = 0; we_a = 0; ena_b = 0; we_b = 0; col_clr = 0;
  endtask

  // One clock edge: the model consumes the inputs present at the edge, then the
  // task returns at the following negedge where outputs are stable.
  task automatic step();
    logic [15:0] ra;
    logic [3:0]  rb;
    bit          coll;
    int          ai, bi;
    @(posedge clk);
    cyc++;
    ai = int'(addr_a);
    bi = int'(addr_b);
    if (ena_a && !we_a) begin
      for (int i = 0; i < 4; i++) ra[4*i +: 4] = nib[4*ai + i];
`ifdef TDP_RAM_BYPASS_EN
      if (ena_b && we_b && (bi / 4) == ai) ra[4*(bi%4) +: 4] = di_b;
`endif
      qa.push_back('{cyc + N, ra});
    end
    if (ena_b && !we_b) begin
      rb = nib[bi];
`ifdef TDP_RAM_BYPASS_EN
      if (ena_a && we_a && ai == (bi / 4)) rb = di_a[4*(bi%4) +: 4];
`endif
      qb.push_back('{cyc + N, 16'(rb)});
    end
    coll = ena_a && we_a && ena_b && we_b && (ai == bi / 4);
    if (ena_b && we_b) nib[bi] = di_b;
    if (ena_a && we_a) for (int i = 0; i < 4; i++) nib[4*ai + i] = di_a[4*i +: 4];
    if (col_clr) m_col = coll ? 1 : 0;
    else if (coll && m_col < 65535) m_col++;
    exp_vld_a = 0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      exp_vld_a = 1; last_a = qa[0].val; void'(qa.pop_front());
    end
    exp_vld_b = 0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      exp_vld_b = 1; last_b = qb[0].val[3:0]; void'(qb.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    s_ena_a = 0; s_we_a = 0; s_ena_b = 0; s_we_b = 0; s_col_clr = 0;
    addr_a = '0; addr_b = '0; di_a = '0; di_b = '0;
    s_addr_a = '0; s_addr_b = '0; s_di_a = '0; s_di_b = '0;
    qa.delete(); qb.delete(); last_a = '0; last_b = '0; m_col = 0; cyc = 0;
    repeat (3) @(negedge clk);
    checks++; if ({vld_a, vld_b} !== 2'b00) begin errors++; $display("FAIL reset_vld got=%b exp=00", {vld_a, vld_b}); end
    checks++; if (do_a !== 16'h0) begin errors++; $display("FAIL reset_doA got=%h exp=0000", do_a); end
    checks++; if (do_b !== 4'h0) begin errors++; $display("FAIL reset_doB got=%h exp=0", do_b); end
    checks++; if (col_cnt !== 16'h0) begin errors++; $display("FAIL reset_col got=%h exp=0000", col_cnt); end
    checks++; if ({s_vld_a, s_vld_b} !== 2'b00 || s_do_a !== 32'h0 || s_do_b !== 32'h0) begin
      errors++; $display("FAIL reset_sym got vld=%b doA=%h doB=%h exp zeros", {s_vld_a, s_vld_b}, s_do_a, s_do_b);
    end
    rst_n = 1;
  endtask

  task automatic init_mem();
    for (int w = 0; w < 256; w++) begin
      ena_a = 1; we_a = 1; addr_a = 8'(w); di_a = 16'h0;
      step();
    end
    idle();
    repeat (N + 1) step();
  endtask

  task automatic test_width_mapping();
    logic [3:0] expn [4];
    int r0, idx;
    expn = '{4'hD, 4'hC, 4'hB, 4'hA};
    ena_a = 1; we_a = 1; addr_a = 8'h05; di_a = 16'hABCD;
    step();
    ena_a = 0; we_a = 0;
    r0 = 0;
    for (int s = 0; s < 8; s++) begin
      if (s < 4) begin ena_b = 1; we_b = 0; addr_b = 10'h14 + 10'(s); end
      else ena_b = 0;
      step();
      if (s == 0) r0 = cyc;
      idx = cyc - r0 - N;
      checks++;
      if (vld_b !== (idx >= 0 && idx < 4)) begin
        errors++; $display("FAIL width_vldB step=%0d got=%b", s, vld_b);
      end
      if (idx >= 0) begin
        checks++;
        if (do_b !== expn[(idx < 4) ? idx : 3]) begin
          errors++; $display("FAIL width_doB step=%0d got=%h exp=%h", s, do_b, expn[(idx < 4) ? idx : 3]);
        end
      end
    end
  endtask

  task automatic test_narrow_write();
    ena_b = 1; we_b = 1; addr_b = 10'h1A; di_b = 4'h7;
    step();
    ena_b = 0; we_b = 0;
    ena_a = 1; we_a = 0; addr_a = 8'h06;
    step();
    ena_a = 0;
    for (int s = 1; s <= N + 1; s++) begin
      if (s > 1) step();
      checks++;
      if (vld_a !== (s == 1 + N - N ? (N == 0) : 1'b0) && s <= N) begin
        errors++; $display("FAIL narrow_early_vldA step=%0d got=%b exp=0", s, vld_a);
      end
    end
    checks++;
    if (vld_a !== 1'b1 || do_a !== 16'h0700) begin
      errors++; $display("FAIL narrow_read got vld=%b do=%h exp vld=1 do=0700", vld_a, do_a);
    end
    step();
    checks++;
    if (vld_a !== 1'b0 || do_a !== 16'h0700) begin
      errors++; $display("FAIL narrow_hold got vld=%b do=%h exp vld=0 do=0700", vld_a, do_a);
    end
  endtask

  task automatic collide(input bit clr);
    ena_a = 1; we_a = 1; addr_a = 8'h05; di_a = 16'h1111;
    ena_b = 1; we_b = 1; addr_b = 10'h14; di_b = 4'hF;
    col_clr = clr;
    step();
    idle();
  endtask

  task automatic test_collision();
    col_clr = 1; step(); idle();
    checks++; if (col_cnt !== 16'd0) begin errors++; $display("FAIL col_clear got=%h exp=0000", col_cnt); end
    collide(0);
    checks++; if (col_cnt !== 16'd1) begin errors++; $display("FAIL col_first got=%h exp=0001", col_cnt); end
    ena_a = 1; we_a = 0; addr_a = 8'h05;
    step(); idle();
    repeat (N) step();
    checks++;
    if (vld_a !== 1'b1 || do_a !== 16'h1111) begin
      errors++; $display("FAIL col_a_wins got vld=%b do=%h exp vld=1 do=1111", vld_a, do_a);
    end
    collide(0);
    checks++; if (col_cnt !== 16'd2) begin errors++; $display("FAIL col_second got=%h exp=0002", col_cnt); end
    collide(1);
    checks++; if (col_cnt !== 16'd1) begin errors++; $display("FAIL col_clr_and_hit got=%h exp=0001", col_cnt); end
    ena_b = 1; we_b = 1; addr_b = 10'h18; di_b = 4'h3;
    ena_a = 1; we_a = 1; addr_a = 8'h05; di_a = 16'h1111;
    step(); idle();
    checks++; if (col_cnt !== 16'd1) begin errors++; $display("FAIL col_diff_word got=%h exp=0001", col_cnt); end
    for (int i = 0; i < 65540; i++) collide(0);
    checks++; if (col_cnt !== 16'hFFFF) begin errors++; $display("FAIL col_saturate got=%h exp=ffff", col_cnt); end
    col_clr = 1; step(); idle();
    checks++; if (col_cnt !== 16'd0) begin errors++; $display("FAIL col_clr_from_sat got=%h exp=0000", col_cnt); end
  endtask

  task automatic test_read_during_write();
    ena_a = 1; we_a = 1; addr_a = 8'h07; di_a = 16'h0000;
    step();
    di_a = 16'h2222;
    ena_b = 1; we_b = 0; addr_b = 10'h1C;
    step();
    ena_a = 0; we_a = 0;
    step();
    idle();
    repeat (N - 1) step();
    checks++;
    if (vld_b !== 1'b1 || do_b !== RDW_EXP) begin
      errors++; $display("FAIL rdw_same_cycle got vld=%b do=%h exp vld=1 do=%h", vld_b, do_b, RDW_EXP);
    end
    step();
    checks++;
    if (vld_b !== 1'b1 || do_b !== 4'h2) begin
      errors++; $display("FAIL rdw_next_cycle got vld=%b do=%h exp vld=1 do=2", vld_b, do_b);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    for (int i = 0; i < 3; i++) begin
      ena_a = 1; we_a = 0; addr_a = 8'h05;
      step();
    end
    idle();
    checks++;
    if (vld_a !== 1'b1) begin errors++; $display("FAIL midrst_pre_vld got=%b exp=1", vld_a); end
    rst_n = 0;
    #1;
    checks++;
    if (vld_a !== 1'b0 || do_a !== 16'h0) begin
      errors++; $display("FAIL midrst_async got vld=%b do=%h exp vld=0 do=0000", vld_a, do_a);
    end
    qa.delete(); qb.delete(); last_a = '0; last_b = '0; m_col = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < N + 4; i++) begin
      step();
      if (vld_a !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_stale_vld got pulse exp none"); end
    ena_a = 1; we_a = 0; addr_a = 8'h05;
    step(); idle();
    repeat (N) step();
    checks++;
    if (vld_a !== 1'b1 || do_a !== 16'h1111) begin
      errors++; $display("FAIL midrst_retained got vld=%b do=%h exp vld=1 do=1111", vld_a, do_a);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      ena_a = 1'($urandom); we_a = 1'($urandom);
      ena_b = 1'($urandom); we_b = 1'($urandom);
      addr_a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      addr_b = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 63)) : 10'($urandom);
      di_a = 16'($urandom); di_b = 4'($urandom);
      col_clr = ($urandom_range(0, 19) == 0);
      step();
      checks++;
      if (vld_a !== exp_vld_a) begin errors++; $display("FAIL rnd_vldA cyc=%0d got=%b exp=%b", cyc, vld_a, exp_vld_a); end
      checks++;
      if (do_a !== last_a) begin errors++; $display("FAIL rnd_doA cyc=%0d got=%h exp=%h", cyc, do_a, last_a); end
      checks++;
      if (vld_b !== exp_vld_b) begin errors++; $display("FAIL rnd_vldB cyc=%0d got=%b exp=%b", cyc, vld_b, exp_vld_b); end
      checks++;
      if (do_b !== last_b) begin errors++; $display("FAIL rnd_doB cyc=%0d got=%h exp=%h", cyc, do_b, last_b); end
      checks++;
      if (col_cnt !== 16'(m_col)) begin errors++; $display("FAIL rnd_col cyc=%0d got=%h exp=%h", cyc, col_cnt, 16'(m_col)); end
    end
    idle();
    repeat (N + 1) step();
  endtask

  task automatic test_symmetric();
    logic [8:0]  a;
    logic [31:0] d;
    for (int k = 0; k < 6; k++) begin
      a = (k == 0) ? 9'h1FF : 9'($urandom);
      d = (k == 0) ? 32'hDEADBEEF : $urandom;
      s_ena_a = 1; s_we_a = 1; s_addr_a = a; s_di_a = d;
      @(posedge clk); @(negedge clk);
      s_ena_a = 0; s_we_a = 0;
      s_ena_b = 1; s_we_b = 0; s_addr_b = a;
      @(posedge clk); @(negedge clk);
      s_ena_b = 0;
      checks++;
      if (s_vld_b !== 1'b1 || s_do_b !== d) begin
        errors++; $display("FAIL sym_read k=%0d got vld=%b do=%h exp vld=1 do=%h", k, s_vld_b, s_do_b, d);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (s_vld_b !== 1'b0 || s_do_b !== d) begin
        errors++; $display("FAIL sym_hold k=%0d got vld=%b do=%h exp vld=0 do=%h", k, s_vld_b, s_do_b, d);
      end
    end
    s_ena_a = 1; s_we_a = 1; s_addr_a = 9'h010; s_di_a = 32'h11111111;
    s_ena_b = 1; s_we_b = 1; s_addr_b = 9'h010; s_di_b = 32'h22222222;
    @(posedge clk); @(negedge clk);
    s_we_a = 0; s_ena_b = 0; s_we_b = 0;
    @(posedge clk); @(negedge clk);
    s_ena_a = 0;
    checks++;
    if (s_vld_a !== 1'b1 || s_do_a !== 32'h11111111 || s_col_cnt !== 16'd1) begin
      errors++; $display("FAIL sym_collision got vld=%b do=%h col=%h exp vld=1 do=11111111 col=0001",
                         s_vld_a, s_do_a, s_col_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    init_mem();
    test_symmetric();
    test_width_mapping();
    test_narrow_write();
    test_collision();
    test_read_during_write();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
